// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle between the UART receive FIFO and the control logic that consumes it.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                        rd_en;
    logic                        clear_err;
    logic [DATA_BITS-1:0]        rd_data;
    logic                        rd_valid;
    logic                        rd_frame_err;
    logic                        rd_parity_err;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic                        busy;

    modport master (
        output rd_en, clear_err,
        input  rd_data, rd_valid, rd_frame_err, rd_parity_err, fifo_count, overflow, busy
    );

    modport slave (
        input  rd_en, clear_err,
        output rd_data, rd_valid, rd_frame_err, rd_parity_err, fifo_count, overflow, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a first-word-fall-through FIFO of words tagged with error flags.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input logic           sysclk,
    input logic           reset,
    input logic           serialIn,
    uart_rx_fifo_if.slave rdPort
);
    localparam int DIV    = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCK_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [DIV_W-1:0]    divCnt_q, divCnt_d;
    logic [TCK_W-1:0]    tickCnt_q, tickCnt_d;
    logic [BIT_W-1:0]    bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                parErr_q, parErr_d;
    logic                pushReq_q, pushReq_d;
    logic [WORD_W-1:0]   pushWord_q, pushWord_d;
    logic                rx, tick, halfDone, bitDone;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]         count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                full, notEmpty, pop, wrEn;
    logic [WORD_W-1:0]   head;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serialIn;
            sync2_q <= sync1_q;
        end
    end

    assign rx       = sync2_q;
    assign tick     = (divCnt_q == DIV_W'(DIV - 1));
    assign halfDone = tick && (tickCnt_q == TCK_W'(OVERSAMPLE / 2 - 1));
    assign bitDone  = tick && (tickCnt_q == TCK_W'(OVERSAMPLE - 1));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parErr_q   <= 1'b0;
            pushReq_q  <= 1'b0;
            pushWord_q <= '0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            tickCnt_q  <= tickCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            parErr_q   <= parErr_d;
            pushReq_q  <= pushReq_d;
            pushWord_q <= pushWord_d;
        end
    end

    // The divider idles at zero so the first tick lands a fixed distance after the start edge.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parErr_d   = parErr_q;
        pushReq_d  = 1'b0;
        pushWord_d = pushWord_q;
        if (state_q == IDLE || state_q == BRK || tick) divCnt_d = '0;
        else                                           divCnt_d = divCnt_q + 1'b1;
        if (tick) tickCnt_d = tickCnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
                parErr_d  = 1'b0;
                if (!rx) state_d = START;
            end
            START: begin
                if (halfDone) begin
                    tickCnt_d = '0;
                    state_d   = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    tickCnt_d = '0;
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bitCnt_d  = bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_W'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (bitDone) begin
                    tickCnt_d = '0;
                    parErr_d  = (^shift_q) ^ rx ^ (PARITY == 2);
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a start edge with no idle gap.
                if (bitDone) begin
                    tickCnt_d  = '0;
                    pushReq_d  = 1'b1;
                    pushWord_d = {parErr_q, ~rx, shift_q};
                    state_d    = rx ? IDLE : BRK;
                end
            end
            BRK: begin
                if (rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // At full, a simultaneous pop frees the slot the write pointer already points at.
    always_comb begin
        full     = (count_q == (AW + 1)'(FIFO_DEPTH));
        notEmpty = (count_q != '0);
        pop      = rdPort.rd_en && notEmpty;
        wrEn     = pushReq_q && (!full || pop);
        wrPtr_d  = wrPtr_q + AW'(wrEn);
        rdPtr_d  = rdPtr_q + AW'(pop);
        count_d  = count_q;
        if (wrEn && !pop)      count_d = count_q + 1'b1;
        else if (!wrEn && pop) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (rdPort.clear_err)          ovf_d = 1'b0;
        if (pushReq_q && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (wrEn) mem_q[wrPtr_q] <= pushWord_q;
    end

    assign head                 = mem_q[rdPtr_q];
    assign rdPort.rd_valid      = notEmpty;
    assign rdPort.rd_data       = notEmpty ? head[DATA_BITS-1:0] : '0;
    assign rdPort.rd_frame_err  = notEmpty & head[DATA_BITS];
    assign rdPort.rd_parity_err = notEmpty & head[DATA_BITS+1];
    assign rdPort.fifo_count    = count_q;
    assign rdPort.overflow      = ovf_q;
    assign rdPort.busy          = (state_q != IDLE);
endmodule
